// File: rtl/conv_feeder.sv
// Sequences a loaded filter and activation vector into a MAC as N-M+1 sliding windows.
// Each window is CLEAR, M product cycles, then MAC_LAT drain cycles; every output is a flop.
module conv_feeder #(
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int MAC_LAT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    input  logic signed [13:0]          s_data,
    output logic                        s_ready,
    output logic signed [13:0]          a,
    output logic signed [13:0]          b,
    output logic                        valid_in,
    output logic                        mac_clr,
    output logic                        win_last,
    output logic [$clog2(N-M+2)-1:0]    win_idx,
    output logic                        done
);
    localparam int CW       = $clog2(N + MAC_LAT + 2);
    localparam int WW       = $clog2(N - M + 2);
    localparam int LAT_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    typedef enum logic [2:0] {LOAD_W, LOAD_X, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WW-1:0]      win_n;
    logic [CW:0]        xi;
    logic               end_win;
    logic signed [13:0] a_n, b_n;
    logic signed [13:0] w [M];
    logic signed [13:0] x [N];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        win_n   = win_idx;
        end_win = 1'b0;
        case (state)
            LOAD_W: if (s_valid && s_ready) begin
                if (cnt == CW'(M - 1)) begin
                    state_n = LOAD_X;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LOAD_X: if (s_valid && s_ready) begin
                if (cnt == CW'(N - 1)) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                    win_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CLEAR: begin
                state_n = STREAM;
                cnt_n   = '0;
            end
            STREAM: begin
                if (cnt == CW'(M - 1)) begin
                    cnt_n = '0;
                    if (MAC_LAT == 0) end_win = 1'b1;
                    else              state_n = DRAIN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == CW'(LAT_LAST)) begin
                    cnt_n   = '0;
                    end_win = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = LOAD_W;
                cnt_n   = '0;
            end
            default: begin
                state_n = LOAD_W;
                cnt_n   = '0;
            end
        endcase

        if (end_win) begin
            if (win_idx < WW'(N - M)) begin
                win_n   = win_idx + 1'b1;
                state_n = CLEAR;
            end else begin
                state_n = DONE;
            end
        end
    end

    // Operands are selected for the next state so they land in the same cycle as valid_in.
    always_comb begin
        xi  = (CW+1)'(win_n) + (CW+1)'(cnt_n);
        a_n = '0;
        b_n = '0;
        if (state_n == STREAM) begin
            for (int i = 0; i < N; i++)
                if (xi == (CW+1)'(i)) a_n = x[i];
            for (int i = 0; i < M; i++)
                if (cnt_n == CW'(i)) b_n = w[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD_W;
            cnt      <= '0;
            win_idx  <= '0;
            s_ready  <= 1'b1;
            mac_clr  <= 1'b1;
            valid_in <= 1'b0;
            win_last <= 1'b0;
            done     <= 1'b0;
            a        <= '0;
            b        <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            win_idx  <= win_n;
            s_ready  <= (state_n == LOAD_W) || (state_n == LOAD_X);
            mac_clr  <= (state_n == LOAD_W) || (state_n == LOAD_X) ||
                        (state_n == CLEAR)  || (state_n == DONE);
            valid_in <= (state_n == STREAM);
            win_last <= (state_n == STREAM) && (cnt_n == CW'(M - 1));
            done     <= (state_n == DONE);
            a        <= a_n;
            b        <= b_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && s_valid && s_ready) begin
            if (state == LOAD_W)
                for (int i = 0; i < M; i++)
                    if (cnt == CW'(i)) w[i] <= s_data;
            if (state == LOAD_X)
                for (int i = 0; i < N; i++)
                    if (cnt == CW'(i)) x[i] <= s_data;
        end
    end
endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench: an N=8/M=4/MAC_LAT=2 feeder plus an M=N=4, MAC_LAT=0 feeder,
// each with a small accumulator model standing in for the downstream MAC.
module tb_conv_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst0, s_valid0, s_ready0, valid_in0, mac_clr0, win_last0, done0;
    logic signed [13:0] s_data0, a0, b0;
    logic [2:0]         win_idx0;
    logic               rst1, s_valid1, s_ready1, valid_in1, mac_clr1, win_last1, done1;
    logic signed [13:0] s_data1, a1, b1;
    logic [0:0]         win_idx1;

    conv_feeder #(.N(8), .M(4), .MAC_LAT(2)) dut0 (
        .clk(clk), .reset(rst0), .s_valid(s_valid0), .s_data(s_data0), .s_ready(s_ready0),
        .a(a0), .b(b0), .valid_in(valid_in0), .mac_clr(mac_clr0), .win_last(win_last0),
        .win_idx(win_idx0), .done(done0)
    );

    conv_feeder #(.N(4), .M(4), .MAC_LAT(0)) dut1 (
        .clk(clk), .reset(rst1), .s_valid(s_valid1), .s_data(s_data1), .s_ready(s_ready1),
        .a(a1), .b(b1), .valid_in(valid_in1), .mac_clr(mac_clr1), .win_last(win_last1),
        .win_idx(win_idx1), .done(done1)
    );

    int f0, f1;
    always @(posedge clk) begin
        if (mac_clr0)       f0 <= 0;
        else if (valid_in0) f0 <= f0 + int'(a0) * int'(b0);
        if (mac_clr1)       f1 <= 0;
        else if (valid_in1) f1 <= f1 + int'(a1) * int'(b1);
    end

    int nvec = 0;
    int nerr = 0;
    int wv [4];
    int xv [8];

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Weights then activations; with gaps, a junk word sits on the bus with s_valid low.
    task automatic load_all0(input bit gaps);
        for (int i = 0; i < 12; i++) begin
            s_valid0 = 1'b1;
            s_data0  = (i < 4) ? 14'(wv[i]) : 14'(xv[i-4]);
            tick();
            if (gaps && i < 11) begin
                s_valid0 = 1'b0;
                s_data0  = 14'sh1555;
                tick();
            end
        end
        s_valid0 = 1'b0;
        s_data0  = '0;
    endtask

    // Entered in the CLEAR cycle right after the last load word was accepted.
    task automatic run0();
        int edges = 0;
        int exp;
        for (int k = 0; k < 5; k++) begin
            chk("clear_mac_clr", int'(mac_clr0), 1);
            chk("clear_valid", int'(valid_in0), 0);
            chk("clear_ready", int'(s_ready0), 0);
            chk("win_idx", int'(win_idx0), k);
            exp = 0;
            for (int j = 0; j < 4; j++) begin
                tick(); edges++;
                chk("stream_a", int'(a0), xv[k+j]);
                chk("stream_b", int'(b0), wv[j]);
                chk("stream_valid", int'(valid_in0), 1);
                chk("stream_mac_clr", int'(mac_clr0), 0);
                chk("win_last", int'(win_last0), int'(j == 3));
                exp += xv[k+j] * wv[j];
            end
            for (int d = 0; d < 2; d++) begin
                tick(); edges++;
                chk("drain_valid", int'(valid_in0), 0);
                chk("drain_a", int'(a0), 0);
                chk("drain_b", int'(b0), 0);
                chk("drain_f", f0, exp);
            end
            tick(); edges++;
        end
        chk("done", int'(done0), 1);
        chk("done_mac_clr", int'(mac_clr0), 1);
        chk("done_latency", edges, 35);
        tick();
        chk("done_pulse", int'(done0), 0);
        chk("back_to_load_ready", int'(s_ready0), 1);
        chk("back_to_load_clr", int'(mac_clr0), 1);
    endtask

    initial begin
        rst0 = 1'b1; s_valid0 = 1'b0; s_data0 = '0;
        rst1 = 1'b1; s_valid1 = 1'b0; s_data1 = '0;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;
        chk("rst_ready", int'(s_ready0), 1);
        chk("rst_mac_clr", int'(mac_clr0), 1);
        chk("rst_valid", int'(valid_in0), 0);
        chk("rst_win_last", int'(win_last0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_a", int'(a0), 0);
        chk("rst_b", int'(b0), 0);
        chk("rst_win_idx", int'(win_idx0), 0);

        // Windows sum to 30,40,50,60,70.
        wv = '{1, 2, 3, 4};
        xv = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_all0(1'b0);
        run0();

        load_all0(1'b1);
        run0();

        wv = '{-1, -8192, 8191, 2};
        xv = '{-3, 5, -7, 100, -8192, 8191, 1, -1};
        load_all0(1'b0);
        chk("neg_clear_f", f0, 0);
        run0();

        // Abort mid-stream in window 1, with a word offered during reset.
        wv = '{1, 2, 3, 4};
        xv = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_all0(1'b0);
        for (int i = 0; i < 9; i++) tick();
        chk("pre_rst_win", int'(win_idx0), 1);
        chk("pre_rst_a", int'(a0), 3);
        rst0 = 1'b1; s_valid0 = 1'b1; s_data0 = 14'sd777;
        tick();
        rst0 = 1'b0; s_valid0 = 1'b0; s_data0 = '0;
        chk("abort_valid", int'(valid_in0), 0);
        chk("abort_mac_clr", int'(mac_clr0), 1);
        chk("abort_ready", int'(s_ready0), 1);
        chk("abort_a", int'(a0), 0);
        chk("abort_win_idx", int'(win_idx0), 0);
        chk("abort_done", int'(done0), 0);
        load_all0(1'b0);
        run0();

        // M=N=4, MAC_LAT=0: one window, sum 2-2+9+20 = 29, DONE right after win_last.
        begin
            int w1 [4] = '{2, -1, 3, 5};
            int nlast = 0;
            for (int i = 0; i < 8; i++) begin
                s_valid1 = 1'b1;
                s_data1  = (i < 4) ? 14'(w1[i]) : 14'(i - 3);
                tick();
            end
            s_valid1 = 1'b0;
            chk("m1_clear", int'(mac_clr1), 1);
            chk("m1_win_idx", int'(win_idx1), 0);
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("m1_a", int'(a1), j + 1);
                chk("m1_b", int'(b1), w1[j]);
                if (win_last1) nlast++;
            end
            tick();
            chk("m1_win_last_count", nlast, 1);
            chk("m1_done", int'(done1), 1);
            chk("m1_done_valid", int'(valid_in1), 0);
            chk("m1_f", f1, 29);
            tick();
            chk("m1_done_pulse", int'(done1), 0);
            chk("m1_load_w", int'(s_ready1), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameter N, default 8: input (activation) vector length, N >= 1.
REQ-002 Parameter M, default 4: filter length, 1 <= M <= N.
REQ-003 Parameter MAC_LAT, default 2: cycles from the last product on a/b until f is final in the downstream MAC, >= 0.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high; sampled on posedge clk.
REQ-006 s_valid  input  1  load word present on s_data.
REQ-007 s_data  input  14  signed load word: M weights first, then N activations.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 a  output  14  signed activation operand to the MAC.
REQ-010 b  output  14  signed weight operand to the MAC.
REQ-011 valid_in  output  1  a/b hold a product term this cycle.
REQ-012 mac_clr  output  1  clear to the MAC accumulator (drives MAC reset).
REQ-013 win_last  output  1  high with the final product term of a window.
REQ-014 win_idx  output  $clog2(N-M+2)  index of the window being streamed.
REQ-015 done  output  1  one-cycle pulse after the last window drains.

Function
REQ-016 The FSM SHALL have exactly the states LOAD_W, LOAD_X, CLEAR, STREAM, DRAIN and DONE; all outputs SHALL be registered.
REQ-017 A load word SHALL be accepted only on cycles with s_valid=1 and s_ready=1; s_valid while s_ready=0 SHALL be ignored.
REQ-018 LOAD_W: s_ready=1, mac_clr=1; accepted words SHALL be stored as w[0..M-1] in order; after the M-th accepted word -> LOAD_X.
REQ-019 LOAD_X: s_ready=1, mac_clr=1; accepted words SHALL be stored as x[0..N-1] in order; after the N-th accepted word -> CLEAR, with win_idx=0.
REQ-020 CLEAR: lasts exactly 1 cycle; mac_clr=1, valid_in=0; then -> STREAM.
REQ-021 STREAM: lasts exactly M cycles; on cycle j (0..M-1) the outputs SHALL be a=x[win_idx+j], b=w[j], valid_in=1, mac_clr=0; win_last=1 only on j=M-1.
REQ-022 DRAIN: lasts exactly MAC_LAT cycles (skipped when MAC_LAT=0); valid_in=0, mac_clr=0, so f holds the window's sum.
REQ-023 After DRAIN, if win_idx < N-M, win_idx SHALL increment and the FSM -> CLEAR; otherwise -> DONE.
REQ-024 DONE: lasts 1 cycle with done=1 and mac_clr=1; then -> LOAD_W. Stored x and w SHALL be overwritten only by a new load.
REQ-025 s_ready SHALL be 0 in CLEAR, STREAM, DRAIN and DONE.
REQ-026 The number of windows SHALL be N-M+1. M=N SHALL give one window.
REQ-027 Data SHALL pass bit-exact; signed and negative values SHALL NOT be modified or extended.
REQ-028 a and b SHALL be 0 whenever valid_in=0.
REQ-029 Stream timing SHALL be fixed: the time from the last load word to done SHALL be (N-M+1)*(1+M+MAC_LAT) cycles; no stalls.

Reset
REQ-030 While reset=1 at a posedge, the next-cycle outputs SHALL be: state LOAD_W, s_ready=1, mac_clr=1, valid_in=0, win_last=0, done=0, a=0, b=0, win_idx=0, and load counters at 0.
REQ-031 Reset asserted in any state, including mid-STREAM or mid-load, SHALL abort the operation with the values of REQ-030; stored x/w contents are don't-care.
REQ-032 Reset SHALL take priority over s_valid in the same cycle, and that word SHALL be discarded.

Verification
REQ-033 N=8, M=4, MAC_LAT=2; load w=1,2,3,4 and x=1..8 back-to-back -> window 0 streams a=1,2,3,4 and b=1,2,3,4; the MAC-model f sampled in DRAIN is 30,40,50,60,70 for win_idx 0..4; done is asserted 35 cycles after the last load word.
REQ-034 Load with s_valid toggling 1,0,1,0 -> only the valid words are stored, and the streamed values match gapless loading.
REQ-035 Negative data: w=-1,-8192,8191,2 and x=-3 etc. -> a/b equal the loaded bit patterns exactly, and window 0 sum matches a signed model.
REQ-036 M=N=4 -> exactly one CLEAR/STREAM/DRAIN sequence, win_last once, then done, then LOAD_W.
REQ-037 Reset asserted on cycle 2 of STREAM of window 1 -> on the next cycle valid_in=0, mac_clr=1, s_ready=1; a fresh load then runs normally from window 0.
REQ-038 MAC_LAT=0 -> the cycle after win_last is CLEAR (or DONE after the last window), and the cycle counts match REQ-029.
